// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic: forwarding select
// encodings, the mult/div tracker state type and the register-0 compare helper.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // True when a producer destination matches a consumer source; $zero never matches.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Tracks the multi-cycle mult/div unit: goes BUSY on a start, counts down the
// remaining latency and pulses o_done for one cycle when HI/LO become valid.
// A start seen while BUSY is ignored (the ID-stage stall prevents it anyway).
// A start in the same cycle as o_done is accepted because the FSM is back in IDLE.
module muldiv_tracker
  import mips_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_start,
  output logic      o_busy,
  output logic      o_done,
  output md_state_t o_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  md_state_t        r_state;
  md_state_t        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_done;
  logic             w_next_done;

  // State, counter and done-pulse registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_done  <= w_next_done;
    end
  end

  // Next-state logic: load the count on start, count down while busy.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_done  = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
          w_next_state = MD_BUSY;
          w_next_cnt   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        w_next_cnt = r_cnt - CNT_LAST;
        if (r_cnt == CNT_LAST) begin
          w_next_state = MD_IDLE;
          w_next_done  = 1'b1;
        end
      end
      default: begin
        w_next_state = MD_IDLE;
      end
    endcase
  end

  assign o_busy  = (r_state == MD_BUSY);
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline.
// Forwarding selects, stalls and flushes are purely combinational; the
// mult/div occupancy is tracked by muldiv_tracker. While rst_n is low the
// pipeline is held flushed and un-stalled, forwarding still follows inputs.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       MulDivStartE,
  input  logic       MulDivUseD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MulDivBusy,
  output logic       MulDivDone
);

  md_state_t w_md_state;
  logic      w_lwstall;
  logic      w_brstall;
  logic      w_mdstall;
  logic      w_stall;

  muldiv_tracker #(
    .MULDIV_CYCLES(MULDIV_CYCLES),
    .CNT_W        (CNT_W)
  ) u_muldiv_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(MulDivStartE),
    .o_busy (MulDivBusy),
    .o_done (MulDivDone),
    .o_state(w_md_state)
  );

  // EX operand forwarding: the younger MEM result takes priority over WB.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && reg_match(RsE, WriteRegM))      ForwardAE = FWD_MEM;
    else if (RegWriteW && reg_match(RsE, WriteRegW)) ForwardAE = FWD_WB;
    if (RegWriteM && reg_match(RtE, WriteRegM))      ForwardBE = FWD_MEM;
    else if (RegWriteW && reg_match(RtE, WriteRegW)) ForwardBE = FWD_WB;
  end

  // ID branch comparator forwarding and the three stall sources.
  always_comb begin
    ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
    ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);
    w_lwstall = MemtoRegE && (reg_match(RtE, RsD) || reg_match(RtE, RtD));
    w_brstall = BranchD &&
                ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                 (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
    w_mdstall = MulDivUseD && (w_md_state == MD_BUSY);
    w_stall   = w_lwstall || w_brstall || w_mdstall;
  end

  // Stall/flush outputs; a stall suppresses the taken-branch flush of IF/ID.
  always_comb begin
    StallF = rst_n && w_stall;
    StallD = rst_n && w_stall;
    FlushE = !rst_n || w_stall;
    FlushD = !rst_n || (PCSrcD && !w_stall);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model that tracks mult/div operations
// by the cycle number of their start.
module tb_hazard_ctrl;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, MulDivStartE, MulDivUseD;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MulDivBusy, MulDivDone;
  logic [1:0] ForwardAE, ForwardBE;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MulDivStartE(MulDivStartE), .MulDivUseD(MulDivUseD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: cycle counter and the cycle of the last accepted start.
  int cyc = 0;
  int m_s = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit model_busy();
    return m_valid && (cyc >= m_s + 1) && (cyc <= m_s + MC - 1);
  endfunction

  function automatic bit model_done();
    return m_valid && (cyc == m_s + MC);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_valid <= 1'b0;
    else if (MulDivStartE && !model_busy()) begin
      m_s     <= cyc;
      m_valid <= 1'b1;
    end
  end

  function automatic bit hits(input logic [4:0] p, input logic [4:0] a, input logic [4:0] b);
    return (p != 5'd0) && ((p == a) || (p == b));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (src != 5'd0 && RegWriteM && WriteRegM == src) return 2'b10;
    if (src != 5'd0 && RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,ForwardAD,ForwardBD,Busy,Done}
  function automatic logic [11:0] exp_vec();
    bit lw, br, md, st, busy, done;
    busy = rst_n && model_busy();
    done = rst_n && model_done();
    lw   = MemtoRegE && hits(RtE, RsD, RtD);
    br   = BranchD && ((RegWriteE && hits(WriteRegE, RsD, RtD)) ||
                       (MemtoRegM && hits(WriteRegM, RsD, RtD)));
    md   = MulDivUseD && busy;
    st   = lw || br || md;
    if (!rst_n) return {1'b0, 1'b0, 1'b1, 1'b1, fwd_sel(RsE), fwd_sel(RtE),
                        1'b0 | (RegWriteM && hits(WriteRegM, RsD, 5'd0)),
                        1'b0 | (RegWriteM && hits(WriteRegM, RtD, 5'd0)), 1'b0, 1'b0};
    return {st, st, PCSrcD && !st, st, fwd_sel(RsE), fwd_sel(RtE),
            RegWriteM && hits(WriteRegM, RsD, 5'd0),
            RegWriteM && hits(WriteRegM, RtD, 5'd0), busy, done};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
            MulDivBusy, MulDivDone};
  endfunction

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, PCSrcD, MulDivStartE, MulDivUseD} = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    next_cycle();
    RegWriteM = 1'b1; WriteRegM = 5'd3; RsE = 5'd3;
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; MulDivStartE = 1'b1;
    #3;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      errors++; $display("FAIL reset_stall_flush: got %b want 0011", {StallF, StallD, FlushD, FlushE});
    end
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL reset_forward: got %b want 10", ForwardAE);
    end
    next_cycle();
    #3;
    checks++;
    if ({MulDivBusy, MulDivDone} !== 2'b00) begin
      errors++; $display("FAIL reset_muldiv: got %b want 00", {MulDivBusy, MulDivDone});
    end
    next_cycle();
    drive_idle();
    rst_n = 1'b1;
    #3;
    checks++;
    if ({StallF, FlushD, FlushE, MulDivBusy} !== 4'b0000) begin
      errors++; $display("FAIL reset_release: got %b want 0000", {StallF, FlushD, FlushE, MulDivBusy});
    end
  endtask

  task automatic test_forward_priority();
    next_cycle();
    drive_idle();
    RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd8; WriteRegW = 5'd8; RsE = 5'd8;
    #3;
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_over_wb: got %b want 10", ForwardAE);
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_wb: got %b want 01", ForwardAE);
    end
    RtE = 5'd8; RsE = 5'd2;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      errors++; $display("FAIL fwd_b_wb: got %b want 0001", {ForwardAE, ForwardBE});
    end
  endtask

  task automatic test_reg_zero();
    next_cycle();
    drive_idle();
    RegWriteM = 1'b1; WriteRegM = 5'd0; RsE = 5'd0; RsD = 5'd0;
    MemtoRegE = 1'b1; RtE = 5'd0; RtD = 5'd0;
    #3;
    checks++;
    if ({ForwardAE, ForwardAD, StallF, FlushE} !== 5'b00000) begin
      errors++; $display("FAIL reg_zero: got %b want 00000", {ForwardAE, ForwardAD, StallF, FlushE});
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    drive_idle();
    MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9; PCSrcD = 1'b1;
    #3;
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      errors++; $display("FAIL load_use: got %b want 1110", {StallF, StallD, FlushE, FlushD});
    end
    next_cycle();
    drive_idle();
    PCSrcD = 1'b1;
    #3;
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b0001) begin
      errors++; $display("FAIL load_use_after: got %b want 0001", {StallF, StallD, FlushE, FlushD});
    end
  endtask

  task automatic test_branch();
    next_cycle();
    drive_idle();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd4; RtD = 5'd4;
    #3;
    checks++;
    if ({StallF, FlushE} !== 2'b11) begin
      errors++; $display("FAIL branch_ex_stall: got %b want 11", {StallF, FlushE});
    end
    next_cycle();
    drive_idle();
    BranchD = 1'b1; RtD = 5'd4; RegWriteM = 1'b1; WriteRegM = 5'd4;
    #3;
    checks++;
    if ({ForwardBD, StallF, FlushE} !== 3'b100) begin
      errors++; $display("FAIL branch_mem_fwd: got %b want 100", {ForwardBD, StallF, FlushE});
    end
    MemtoRegM = 1'b1;
    #1;
    checks++;
    if (StallD !== 1'b1) begin
      errors++; $display("FAIL branch_mem_load_stall: got %b want 1", StallD);
    end
  endtask

  task automatic test_muldiv_seq();
    next_cycle();
    drive_idle();
    MulDivStartE = 1'b1; MulDivUseD = 1'b1;
    #3;
    checks++;
    if ({StallD, MulDivBusy} !== 2'b00) begin
      errors++; $display("FAIL md_cycle0: got %b want 00", {StallD, MulDivBusy});
    end
    for (int k = 1; k < MC; k++) begin
      next_cycle();
      MulDivStartE = 1'b0;
      #3;
      checks++;
      if ({StallD, MulDivBusy, MulDivDone} !== 3'b110) begin
        errors++; $display("FAIL md_busy_c%0d: got %b want 110", k, {StallD, MulDivBusy, MulDivDone});
      end
    end
    next_cycle();
    #3;
    checks++;
    if ({StallD, MulDivBusy, MulDivDone} !== 3'b001) begin
      errors++; $display("FAIL md_done: got %b want 001", {StallD, MulDivBusy, MulDivDone});
    end
    next_cycle();
    drive_idle();
    #3;
    checks++;
    if (MulDivDone !== 1'b0) begin
      errors++; $display("FAIL md_done_pulse: got %b want 0", MulDivDone);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive_idle();
    MulDivStartE = 1'b1;
    for (int k = 1; k <= MC; k++) begin
      next_cycle();
      MulDivStartE = (k == MC);
      #3;
    end
    checks++;
    if ({MulDivDone, StallD} !== 2'b10) begin
      errors++; $display("FAIL b2b_done: got %b want 10", {MulDivDone, StallD});
    end
    next_cycle();
    MulDivStartE = 1'b0;
    #3;
    checks++;
    if ({MulDivBusy, MulDivDone} !== 2'b10) begin
      errors++; $display("FAIL b2b_restart: got %b want 10", {MulDivBusy, MulDivDone});
    end
    for (int k = 2; k <= MC; k++) begin
      next_cycle();
      #3;
    end
    checks++;
    if ({MulDivBusy, MulDivDone} !== 2'b01) begin
      errors++; $display("FAIL b2b_second_done: got %b want 01", {MulDivBusy, MulDivDone});
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen_done;
    next_cycle();
    drive_idle();
    MulDivStartE = 1'b1; MulDivUseD = 1'b1;
    next_cycle();
    MulDivStartE = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({MulDivBusy, FlushD, FlushE, StallD} !== 4'b0110) begin
      errors++; $display("FAIL rst_mid_busy: got %b want 0110", {MulDivBusy, FlushD, FlushE, StallD});
    end
    next_cycle();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < MC + 3; k++) begin
      #3;
      if (MulDivDone || MulDivBusy) seen_done = 1'b1;
      next_cycle();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL rst_no_done: got %b want 0", seen_done);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [11:0] e, o;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 79) != 0);
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD = 1'($urandom); PCSrcD = 1'($urandom);
      MulDivStartE = ($urandom_range(0, 5) == 0); MulDivUseD = 1'($urandom);
      #3;
      e = exp_vec();
      o = obs_vec();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL random_cyc%0d: got %b want %b", n, o, e);
      end
    end
    next_cycle();
    rst_n = 1'b1;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_reg_zero();
    test_load_use();
    test_branch();
    test_muldiv_seq();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
